// File: rtl/vga_timing_ctrl_if.sv
// Pixel-side bundle between the raster timing generator, the pattern stage and the VGA DAC pins.
// The master modport is the timing controller; the slave modport is the pattern stage / board side.
interface vga_timing_ctrl_if;
    logic [9:0] iRed;
    logic [9:0] iGreen;
    logic [9:0] iBlue;
    logic [9:0] oVGA_X;
    logic [9:0] oVGA_Y;
    logic       oRequest;
    logic       oFrameStart;
    logic [9:0] oVGA_R;
    logic [9:0] oVGA_G;
    logic [9:0] oVGA_B;
    logic       oVGA_HS;
    logic       oVGA_VS;
    logic       oVGA_BLANK_N;

    modport master (
        input  iRed, iGreen, iBlue,
        output oVGA_X, oVGA_Y, oRequest, oFrameStart,
        output oVGA_R, oVGA_G, oVGA_B, oVGA_HS, oVGA_VS, oVGA_BLANK_N
    );

    modport slave (
        output iRed, iGreen, iBlue,
        input  oVGA_X, oVGA_Y, oRequest, oFrameStart,
        input  oVGA_R, oVGA_G, oVGA_B, oVGA_HS, oVGA_VS, oVGA_BLANK_N
    );
endinterface

// File: rtl/vga_timing_ctrl.sv
// Raster timing generator and DAC output stage; sync/blank are delayed to match the pattern stage latency.
// Optional VGA_BORDER_EN: paints a full-scale white frame on the outermost active rows and columns.
module vga_timing_ctrl #(
    parameter int H_ACT    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACT    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIPE_LAT = 1,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic              iVGA_CLK,
    input  logic              iRST,
    vga_timing_ctrl_if.master vif
);
    localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] C_H_ACT  = 10'(H_ACT);
    localparam logic [9:0] C_HS_BEG = 10'(H_ACT + H_FP);
    localparam logic [9:0] C_HS_END = 10'(H_ACT + H_FP + H_SYNC);
    localparam logic [9:0] C_H_LAST = 10'(H_TOT - 1);
    localparam logic [9:0] C_V_ACT  = 10'(V_ACT);
    localparam logic [9:0] C_VS_BEG = 10'(V_ACT + V_FP);
    localparam logic [9:0] C_VS_END = 10'(V_ACT + V_FP + V_SYNC);
    localparam logic [9:0] C_V_LAST = 10'(V_TOT - 1);

`ifdef VGA_BORDER_EN
    localparam logic [9:0] C_H_EDGE = 10'(H_ACT - 1);
    localparam logic [9:0] C_V_EDGE = 10'(V_ACT - 1);
    localparam int PW = 4;
`else
    localparam int PW = 3;
`endif

    logic [9:0]    r_h_cnt;
    logic [9:0]    r_v_cnt;
    logic          w_h_act;
    logic          w_v_act;
    logic          w_act;
    logic          w_hs;
    logic          w_vs;
    logic [PW-1:0] w_dec;
    logic [PW-1:0] w_tail;
    logic [PW-1:0] r_pipe [PIPE_LAT];
    logic [9:0]    r_red;
    logic [9:0]    r_green;
    logic [9:0]    r_blue;
    logic          r_hs;
    logic          r_vs;
    logic          r_blank_n;

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == C_H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == C_V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 10'd1;
        end
    end

    assign w_h_act = (r_h_cnt < C_H_ACT);
    assign w_v_act = (r_v_cnt < C_V_ACT);
    assign w_act   = w_h_act && w_v_act;
    assign w_hs    = (r_h_cnt >= C_HS_BEG) && (r_h_cnt < C_HS_END);
    assign w_vs    = (r_v_cnt >= C_VS_BEG) && (r_v_cnt < C_VS_END);

    // Delay-line word: {border, vs, hs, act}, syncs held as "asserted" flags until the pin stage.
`ifdef VGA_BORDER_EN
    assign w_dec = {w_act && (r_h_cnt == 10'd0 || r_h_cnt == C_H_EDGE ||
                              r_v_cnt == 10'd0 || r_v_cnt == C_V_EDGE),
                    w_vs, w_hs, w_act};
`else
    assign w_dec = {w_vs, w_hs, w_act};
`endif

    assign vif.oVGA_X      = w_act ? r_h_cnt : 10'd0;
    assign vif.oVGA_Y      = w_act ? r_v_cnt : 10'd0;
    assign vif.oRequest    = w_act;
    assign vif.oFrameStart = (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            for (int i = 0; i < PIPE_LAT; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= w_dec;
            for (int i = 1; i < PIPE_LAT; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign w_tail = r_pipe[PIPE_LAT-1];

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            r_red     <= '0;
            r_green   <= '0;
            r_blue    <= '0;
            r_hs      <= ~SYNC_POL;
            r_vs      <= ~SYNC_POL;
            r_blank_n <= 1'b0;
        end else begin
            r_hs      <= w_tail[1] ? SYNC_POL : ~SYNC_POL;
            r_vs      <= w_tail[2] ? SYNC_POL : ~SYNC_POL;
            r_blank_n <= w_tail[0];
            if (!w_tail[0]) begin
                r_red   <= '0;
                r_green <= '0;
                r_blue  <= '0;
`ifdef VGA_BORDER_EN
            end else if (w_tail[3]) begin
                r_red   <= 10'h3FF;
                r_green <= 10'h3FF;
                r_blue  <= 10'h3FF;
`endif
            end else begin
                r_red   <= vif.iRed;
                r_green <= vif.iGreen;
                r_blue  <= vif.iBlue;
            end
        end
    end

    assign vif.oVGA_R       = r_red;
    assign vif.oVGA_G       = r_green;
    assign vif.oVGA_B       = r_blue;
    assign vif.oVGA_HS      = r_hs;
    assign vif.oVGA_VS      = r_vs;
    assign vif.oVGA_BLANK_N = r_blank_n;
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: two reduced-raster instances (latency 1 and 3) plus one default-timing instance,
// each fed by a modelled registered pattern stage and checked against a frame-position reference model.
module tb_vga_timing_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_timing_ctrl_if if_a ();
    vga_timing_ctrl_if if_b ();
    vga_timing_ctrl_if if_d ();

    vga_timing_ctrl #(.H_ACT(16), .H_FP(2), .H_SYNC(3), .H_BP(4), .V_ACT(8), .V_FP(2), .V_SYNC(2),
                      .V_BP(3), .PIPE_LAT(1), .SYNC_POL(1'b0))
        u_a (.iVGA_CLK(clk), .iRST(rst), .vif(if_a));
    vga_timing_ctrl #(.H_ACT(16), .H_FP(2), .H_SYNC(3), .H_BP(4), .V_ACT(8), .V_FP(2), .V_SYNC(2),
                      .V_BP(3), .PIPE_LAT(3), .SYNC_POL(1'b0))
        u_b (.iVGA_CLK(clk), .iRST(rst), .vif(if_b));
    vga_timing_ctrl u_d (.iVGA_CLK(clk), .iRST(rst), .vif(if_d));

`ifdef VGA_BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif

    int HA_ [3] = '{16, 16, 640};
    int HF_ [3] = '{2, 2, 16};
    int HS_ [3] = '{3, 3, 96};
    int HB_ [3] = '{4, 4, 48};
    int VA_ [3] = '{8, 8, 480};
    int VF_ [3] = '{2, 2, 10};
    int VS_ [3] = '{2, 2, 2};
    int VB_ [3] = '{3, 3, 33};
    int LAT [3] = '{1, 3, 1};

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int mode = 1;
    int kr = 1, kg = 2, kb = 3;
    logic [9:0] cval = 10'd0;
    logic [29:0] fmod [3][8];
    logic [29:0] fdut [3][8];

    typedef struct packed {
        logic [9:0] x, y;
        logic       req, fs;
        logic [9:0] r, g, b;
        logic       hs, vs, bn;
    } obs_t;

    function automatic obs_t obs(int k);
        obs_t o;
        case (k)
            0: o = '{if_a.oVGA_X, if_a.oVGA_Y, if_a.oRequest, if_a.oFrameStart, if_a.oVGA_R, if_a.oVGA_G,
                     if_a.oVGA_B, if_a.oVGA_HS, if_a.oVGA_VS, if_a.oVGA_BLANK_N};
            1: o = '{if_b.oVGA_X, if_b.oVGA_Y, if_b.oRequest, if_b.oFrameStart, if_b.oVGA_R, if_b.oVGA_G,
                     if_b.oVGA_B, if_b.oVGA_HS, if_b.oVGA_VS, if_b.oVGA_BLANK_N};
            default: o = '{if_d.oVGA_X, if_d.oVGA_Y, if_d.oRequest, if_d.oFrameStart, if_d.oVGA_R, if_d.oVGA_G,
                     if_d.oVGA_B, if_d.oVGA_HS, if_d.oVGA_VS, if_d.oVGA_BLANK_N};
        endcase
        return o;
    endfunction

    // Reference raster: position is simply cycle-count modulo frame length.
    function automatic int ht(int k); return HA_[k] + HF_[k] + HS_[k] + HB_[k]; endfunction
    function automatic int vt(int k); return VA_[k] + VF_[k] + VS_[k] + VB_[k]; endfunction
    function automatic int hpos(int k, int c); return (c % (ht(k) * vt(k))) % ht(k); endfunction
    function automatic int vpos(int k, int c); return (c % (ht(k) * vt(k))) / ht(k); endfunction
    function automatic bit act_m(int k, int c);
        if (c < 0) return 1'b0;
        return hpos(k, c) < HA_[k] && vpos(k, c) < VA_[k];
    endfunction
    function automatic bit hsync_m(int k, int c);
        if (c < 0) return 1'b0;
        return hpos(k, c) >= HA_[k] + HF_[k] && hpos(k, c) < HA_[k] + HF_[k] + HS_[k];
    endfunction
    function automatic bit vsync_m(int k, int c);
        if (c < 0) return 1'b0;
        return vpos(k, c) >= VA_[k] + VF_[k] && vpos(k, c) < VA_[k] + VF_[k] + VS_[k];
    endfunction
    function automatic bit border_m(int k, int c);
        if (!act_m(k, c)) return 1'b0;
        return hpos(k, c) == 0 || hpos(k, c) == HA_[k] - 1 || vpos(k, c) == 0 || vpos(k, c) == VA_[k] - 1;
    endfunction

    function automatic logic [29:0] pat(int x, int y);
        logic [9:0] r, g, b;
        case (mode)
            0: begin
                r = 10'(x * kr + y * kg + 5);
                g = 10'((x ^ y) + kb);
                b = 10'(x * 3 + y * kb);
            end
            1: begin r = 10'h3FF; g = 10'h3FF; b = 10'h3FF; end
            default: begin r = cval; g = cval; b = cval; end
        endcase
        return {r, g, b};
    endfunction

    function automatic logic [29:0] exp_rgb(int k, int c);
        int d;
        d = c - LAT[k] - 1;
        if (!act_m(k, d)) return 30'd0;
        if (BORDER && border_m(k, d)) return {3{10'h3FF}};
        return fmod[k][d & 7];
    endfunction

    // Registered pattern stage of depth LAT, driven from each DUT's own coordinates.
    initial begin
        logic r_s;
        logic [29:0] v;
        obs_t o;
        if_a.iRed = '0; if_a.iGreen = '0; if_a.iBlue = '0;
        if_b.iRed = '0; if_b.iGreen = '0; if_b.iBlue = '0;
        if_d.iRed = '0; if_d.iGreen = '0; if_d.iBlue = '0;
        forever begin
            @(posedge clk);
            r_s = rst;
            #1;
            if (r_s) cyc = 0;
            else cyc++;
            for (int k = 0; k < 3; k++) begin
                o = obs(k);
                fmod[k][cyc & 7] = act_m(k, cyc) ? pat(hpos(k, cyc), vpos(k, cyc)) : pat(0, 0);
                fdut[k][cyc & 7] = pat(int'(o.x), int'(o.y));
                v = (cyc >= LAT[k]) ? fdut[k][(cyc - LAT[k]) & 7] : 30'd0;
                case (k)
                    0: begin if_a.iRed = v[29:20]; if_a.iGreen = v[19:10]; if_a.iBlue = v[9:0]; end
                    1: begin if_b.iRed = v[29:20]; if_b.iGreen = v[19:10]; if_b.iBlue = v[9:0]; end
                    default: begin if_d.iRed = v[29:20]; if_d.iGreen = v[19:10]; if_d.iBlue = v[9:0]; end
                endcase
            end
        end
    end

    task automatic clk_wait();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        obs_t o;
        rst = 1'b1;
        repeat (3) clk_wait();
        for (int k = 0; k < 3; k++) begin
            o = obs(k);
            checks++; if ({o.r, o.g, o.b} !== 30'd0) begin failures++; $display("FAIL reset_rgb inst=%0d got=%h exp=0", k, {o.r, o.g, o.b}); end
            checks++; if (o.hs !== 1'b1) begin failures++; $display("FAIL reset_hs inst=%0d got=%b exp=1", k, o.hs); end
            checks++; if (o.vs !== 1'b1) begin failures++; $display("FAIL reset_vs inst=%0d got=%b exp=1", k, o.vs); end
            checks++; if (o.bn !== 1'b0) begin failures++; $display("FAIL reset_blank_n inst=%0d got=%b exp=0", k, o.bn); end
        end
        rst = 1'b0;
        clk_wait();
        clk_wait();
        rst = 1'b1;
        clk_wait();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            o = obs(k);
            checks++; if (o.x !== 10'd0 || o.y !== 10'd0) begin failures++; $display("FAIL first_xy inst=%0d got=%0d,%0d exp=0,0", k, o.x, o.y); end
            checks++; if (o.req !== 1'b1) begin failures++; $display("FAIL first_req inst=%0d got=%b exp=1", k, o.req); end
            checks++; if (o.fs !== 1'b1) begin failures++; $display("FAIL first_fs inst=%0d got=%b exp=1", k, o.fs); end
        end
        clk_wait();
        o = obs(0);
        checks++; if (o.fs !== 1'b0 || o.x !== 10'd1) begin failures++; $display("FAIL second_clk fs=%b x=%0d exp fs=0 x=1", o.fs, o.x); end
    endtask

    task automatic test_coords();
        obs_t o;
        int n;
        int ex, ey;
        n = $urandom_range(300, 600);
        repeat (n) begin
            clk_wait();
            for (int k = 0; k < 3; k += 2) begin
                o = obs(k);
                ex = act_m(k, cyc) ? hpos(k, cyc) : 0;
                ey = act_m(k, cyc) ? vpos(k, cyc) : 0;
                checks++; if (int'(o.x) !== ex || int'(o.y) !== ey) begin failures++; $display("FAIL coords inst=%0d cyc=%0d got=%0d,%0d exp=%0d,%0d", k, cyc, o.x, o.y, ex, ey); end
                checks++; if (o.req !== act_m(k, cyc)) begin failures++; $display("FAIL request inst=%0d cyc=%0d got=%b exp=%b", k, cyc, o.req, act_m(k, cyc)); end
                checks++; if (o.fs !== (hpos(k, cyc) == 0 && vpos(k, cyc) == 0)) begin failures++; $display("FAIL frame_start inst=%0d cyc=%0d got=%b", k, cyc, o.fs); end
            end
        end
    endtask

    task automatic test_line_timing();
        obs_t o;
        logic prev;
        bit found;
        int n, cf;
        o = obs(2); prev = o.hs; found = 0; n = 0;
        while (!found && n < 2000) begin
            clk_wait(); n++; o = obs(2);
            if (prev && !o.hs) found = 1;
            prev = o.hs;
        end
        checks++; if (!found) begin failures++; $display("FAIL hs_fall_timeout got=none exp=fall within 2000"); return; end
        cf = cyc;
        checks++; if ((cf - 2) % 800 !== 656) begin failures++; $display("FAIL hs_start got=%0d exp=656", (cf - 2) % 800); end
        n = 0;
        while (!o.hs && n < 200) begin clk_wait(); n++; o = obs(2); end
        checks++; if (n !== 96) begin failures++; $display("FAIL hs_width got=%0d exp=96", n); end
        found = 0; n = 0;
        while (!found && n < 1000) begin clk_wait(); n++; o = obs(2); if (!o.hs) found = 1; end
        checks++; if (!found || cyc - cf !== 800) begin failures++; $display("FAIL line_period got=%0d exp=800", cyc - cf); end
    endtask

    task automatic test_frame_timing();
        obs_t o;
        logic prev;
        bit found;
        int n, cf, c1;
        o = obs(0); prev = o.vs; found = 0; n = 0;
        while (!found && n < 800) begin
            clk_wait(); n++; o = obs(0);
            if (prev && !o.vs) found = 1;
            prev = o.vs;
        end
        checks++; if (!found) begin failures++; $display("FAIL vs_fall_timeout got=none exp=fall within 800"); return; end
        cf = cyc;
        checks++; if ((cf - 2) % 375 !== 250) begin failures++; $display("FAIL vs_start got=%0d exp=250", (cf - 2) % 375); end
        n = 0;
        while (!o.vs && n < 200) begin clk_wait(); n++; o = obs(0); end
        checks++; if (n !== 50) begin failures++; $display("FAIL vs_width got=%0d exp=50", n); end
        found = 0; n = 0;
        while (!found && n < 400) begin clk_wait(); n++; o = obs(0); if (o.fs) found = 1; end
        c1 = cyc;
        checks++; if (!found || c1 % 375 !== 0) begin failures++; $display("FAIL fs_phase got=%0d exp=0", c1 % 375); end
        found = 0; n = 0;
        while (!found && n < 400) begin clk_wait(); n++; o = obs(0); if (o.fs) found = 1; end
        checks++; if (!found || cyc - c1 !== 375) begin failures++; $display("FAIL fs_period got=%0d exp=375", cyc - c1); end
    endtask

    task automatic test_blanking();
        obs_t o;
        logic [29:0] e;
        mode = 1;
        repeat (6) clk_wait();
        repeat (400) begin
            clk_wait();
            for (int k = 0; k < 2; k++) begin
                o = obs(k);
                checks++; if (o.bn !== act_m(k, cyc - LAT[k] - 1)) begin failures++; $display("FAIL blank_n inst=%0d cyc=%0d got=%b", k, cyc, o.bn); end
                checks++; if (o.hs !== !hsync_m(k, cyc - LAT[k] - 1) || o.vs !== !vsync_m(k, cyc - LAT[k] - 1)) begin failures++; $display("FAIL syncs inst=%0d cyc=%0d got=%b%b", k, cyc, o.hs, o.vs); end
                e = o.bn ? {3{10'h3FF}} : 30'd0;
                checks++; if ({o.r, o.g, o.b} !== e) begin failures++; $display("FAIL blank_rgb inst=%0d cyc=%0d got=%h exp=%h", k, cyc, {o.r, o.g, o.b}, e); end
            end
        end
        mode = 2;
        cval = 10'($urandom_range(1, 1022));
        repeat (6) clk_wait();
        repeat (400) begin
            clk_wait();
            for (int k = 0; k < 2; k++) begin
                o = obs(k);
                e = exp_rgb(k, cyc);
                checks++; if ({o.r, o.g, o.b} !== e) begin failures++; $display("FAIL const_rgb inst=%0d cyc=%0d got=%h exp=%h", k, cyc, {o.r, o.g, o.b}, e); end
            end
        end
    endtask

    task automatic test_alignment();
        obs_t o;
        logic [29:0] e;
        logic prev_bn [2];
        int ncol0;
        int d;
        mode = 0;
        kr = int'($urandom_range(1, 97));
        kg = int'($urandom_range(1, 97));
        kb = int'($urandom_range(1, 97));
        ncol0 = 0;
        prev_bn[0] = 1'b1;
        prev_bn[1] = 1'b1;
        repeat (450) begin
            clk_wait();
            for (int k = 0; k < 2; k++) begin
                o = obs(k);
                e = exp_rgb(k, cyc);
                checks++; if ({o.r, o.g, o.b} !== e) begin failures++; $display("FAIL align_rgb inst=%0d cyc=%0d got=%h exp=%h", k, cyc, {o.r, o.g, o.b}, e); end
                if (o.bn && !prev_bn[k]) begin
                    d = cyc - LAT[k] - 1;
                    e = (BORDER) ? {3{10'h3FF}} : pat(0, vpos(k, d));
                    ncol0++;
                    checks++; if ({o.r, o.g, o.b} !== e) begin failures++; $display("FAIL col0_pixel inst=%0d row=%0d got=%h exp=%h", k, vpos(k, d), {o.r, o.g, o.b}, e); end
                end
                prev_bn[k] = o.bn;
            end
        end
        checks++; if (ncol0 < 2) begin failures++; $display("FAIL col0_seen got=%0d exp=>=2", ncol0); end
    endtask

    task automatic test_mid_reset();
        obs_t o;
        int target, n;
        logic [29:0] e;
        target = int'($urandom_range(1, 13)) * 25 + int'($urandom_range(0, 24));
        n = 0;
        while ((cyc % 375) != target && n < 400) begin clk_wait(); n++; end
        checks++; if ((cyc % 375) !== target) begin failures++; $display("FAIL midrst_reach got=%0d exp=%0d", cyc % 375, target); end
        rst = 1'b1;
        clk_wait();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            o = obs(k);
            checks++; if (o.bn !== 1'b0 || {o.r, o.g, o.b} !== 30'd0 || o.hs !== 1'b1 || o.vs !== 1'b1) begin failures++; $display("FAIL midrst_blank inst=%0d got bn=%b rgb=%h hs=%b vs=%b", k, o.bn, {o.r, o.g, o.b}, o.hs, o.vs); end
            checks++; if (o.x !== 10'd0 || o.y !== 10'd0 || o.fs !== 1'b1) begin failures++; $display("FAIL midrst_restart inst=%0d got x=%0d y=%0d fs=%b", k, o.x, o.y, o.fs); end
        end
        repeat (380) begin
            clk_wait();
            for (int k = 0; k < 2; k++) begin
                o = obs(k);
                e = exp_rgb(k, cyc);
                checks++; if (o.bn !== act_m(k, cyc - LAT[k] - 1) || {o.r, o.g, o.b} !== e) begin failures++; $display("FAIL midrst_dac inst=%0d cyc=%0d got bn=%b rgb=%h exp rgb=%h", k, cyc, o.bn, {o.r, o.g, o.b}, e); end
                checks++; if (o.fs !== (cyc % 375 == 0)) begin failures++; $display("FAIL midrst_fs inst=%0d cyc=%0d got=%b", k, cyc, o.fs); end
            end
        end
    endtask

`ifdef VGA_BORDER_EN
    task automatic test_border();
        obs_t o;
        logic [29:0] e;
        int d;
        int hits;
        mode = 2;
        cval = 10'd0;
        hits = 0;
        repeat (6) clk_wait();
        repeat (400) begin
            clk_wait();
            o = obs(0);
            d = cyc - 2;
            if (act_m(0, d)) begin
                e = border_m(0, d) ? {3{10'h3FF}} : 30'd0;
                if (hpos(0, d) == 1 && vpos(0, d) == 1) hits++;
                checks++; if ({o.r, o.g, o.b} !== e) begin failures++; $display("FAIL border inst=0 x=%0d y=%0d got=%h exp=%h", hpos(0, d), vpos(0, d), {o.r, o.g, o.b}, e); end
            end
        end
        checks++; if (hits < 1) begin failures++; $display("FAIL border_inner_seen got=%0d exp=>=1", hits); end
    endtask
`endif

    initial begin
        #800000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_coords();
        test_line_timing();
        test_frame_timing();
        test_blanking();
        test_alignment();
        test_mid_reset();
`ifdef VGA_BORDER_EN
        test_border();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
